// File: rtl/multiword_add_pkg.sv
// Shared FSM state encoding and default widths for the multiword adder.
// Optional overflow flag is enabled by defining MULTIWORD_ADD_OVF_EN.
package multiword_add_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NUM_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_add_slice.sv
// Combinational WORD_W-bit adder with carry in/out.
// Shared by all slices of the wide addition.
module word_add_slice #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              ci,
    output logic [WORD_W-1:0] s,
    output logic              co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: one WORD_W slice per cycle, LSW first, carry rippled.
// Define MULTIWORD_ADD_OVF_EN to add the signed overflow output ovf.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    localparam int OP_W     = WORD_W * NUM_WORDS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    input  logic            cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] sum,
    output logic            cout,
    output logic            busy
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [OP_W-1:0]  a_reg;
    logic [OP_W-1:0]  b_reg;
    logic [WORD_W-1:0] s;
    logic             co;

    // Single adder, time-multiplexed over the slices by idx.
    word_add_slice #(.WORD_W(WORD_W)) u_slice (
        .a  (a_reg[idx*WORD_W +: WORD_W]),
        .b  (b_reg[idx*WORD_W +: WORD_W]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
`ifdef MULTIWORD_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        carry    <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*WORD_W +: WORD_W] <= s;
                    carry <= co;
                    if (idx == LAST) begin
                        idx       <= '0;
                        cout      <= co;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef MULTIWORD_ADD_OVF_EN
                        ovf <= (a_reg[OP_W-1] == b_reg[OP_W-1]) &&
                               (s[WORD_W-1] != a_reg[OP_W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq against a wide-integer model.
// Define MULTIWORD_ADD_OVF_EN to also check the overflow flag.
module tb_multiword_add_seq;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int OP_W      = WORD_W * NUM_WORDS;

    typedef logic [OP_W:0] cval_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic            cin;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] sum;
    logic            cout;
    logic            busy;
`ifdef MULTIWORD_ADD_OVF_EN
    logic            ovf;
`endif

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef MULTIWORD_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input cval_t got, input cval_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        logic [OP_W-1:0] v;
        for (int i = 0; i < NUM_WORDS; i++) v[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        return v;
    endfunction

    // Reference: plain wide-integer addition.
    function automatic cval_t model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                    input logic c);
        return cval_t'(a) + cval_t'(b) + cval_t'(c);
    endfunction

    function automatic logic model_ovf(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                       input logic c);
        cval_t r;
        r = model(a, b, c);
        return (a[OP_W-1] == b[OP_W-1]) && (r[OP_W-1] != a[OP_W-1]);
    endfunction

    task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input logic c, input int hold);
        cval_t exp;
        int    lat;
        exp = model(a, b, c);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_idle", cval_t'(in_ready), cval_t'(1'b1));
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        // Inputs must be ignored after accept: drive garbage while busy.
        op_a = ~a; op_b = rand_op(); cin = ~c;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", cval_t'(lat), cval_t'(NUM_WORDS));
        check("sum", cval_t'(sum), cval_t'(exp[OP_W-1:0]));
        check("cout", cval_t'(cout), cval_t'(exp[OP_W]));
        check("busy_done", cval_t'(busy), cval_t'(1'b1));
        check("in_ready_done", cval_t'(in_ready), cval_t'(1'b0));
`ifdef MULTIWORD_ADD_OVF_EN
        check("ovf", cval_t'(ovf), cval_t'(model_ovf(a, b, c)));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", cval_t'(out_valid), cval_t'(1'b1));
            check("hold_sum", {cout, sum}, exp);
            check("hold_in_ready", cval_t'(in_ready), cval_t'(1'b0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", cval_t'(out_valid), cval_t'(1'b0));
        check("release_in_ready", cval_t'(in_ready), cval_t'(1'b1));
        check("release_busy", cval_t'(busy), cval_t'(1'b0));
        check("sum_kept", cval_t'(sum), cval_t'(exp[OP_W-1:0]));
    endtask

    logic [OP_W-1:0] ones;
    logic [OP_W-1:0] smax;
    cval_t           expq[$];
    cval_t           e;
    int              last_out;
    int              got_n;
    int              cyc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        ones = '1;
        smax = {1'b0, {(OP_W-1){1'b1}}};
        repeat (3) @(negedge clk);
        check("rst_in_ready", cval_t'(in_ready), cval_t'(1'b1));
        check("rst_out_valid", cval_t'(out_valid), cval_t'(1'b0));
        check("rst_sum", cval_t'(sum), cval_t'(0));
        check("rst_cout", cval_t'(cout), cval_t'(0));
        check("rst_busy", cval_t'(busy), cval_t'(0));
`ifdef MULTIWORD_ADD_OVF_EN
        check("rst_ovf", cval_t'(ovf), cval_t'(0));
`endif
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_W'(41), OP_W'(3), 1'b1, 0);
        run_op(ones, '0, 1'b1, 0);
        run_op(ones, ones, 1'b1, 5);
        run_op(smax, OP_W'(1), 1'b0, 1);
        run_op(OP_W'(5), OP_W'(3), 1'b0, 0);
        for (int i = 0; i < 12; i++)
            run_op(rand_op(), rand_op(), 1'($urandom), int'($urandom_range(0, 3)));

        // Abort mid-RUN: reset lands on the 2nd RUN edge.
        op_a = rand_op(); op_b = rand_op(); cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", cval_t'(out_valid), cval_t'(1'b0));
        check("abort_sum", cval_t'(sum), cval_t'(0));
        check("abort_in_ready", cval_t'(in_ready), cval_t'(1'b1));
        check("abort_busy", cval_t'(busy), cval_t'(1'b0));
        run_op(OP_W'(1000), OP_W'(2345), 1'b0, 0);

        // Back-to-back streaming with both handshakes held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        got_n = 0; last_out = -1; cyc = 0;
        while (got_n < 10 && cyc < 200) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("stream_unexpected", cval_t'(1), cval_t'(0));
                end else begin
                    e = expq.pop_front();
                    check("stream_result", {cout, sum}, e);
                end
                if (last_out >= 0)
                    check("stream_period", cval_t'(cyc - last_out), cval_t'(NUM_WORDS + 2));
                last_out = cyc;
                got_n++;
            end
            if (in_ready) begin
                op_a = rand_op(); op_b = rand_op(); cin = 1'($urandom);
                expq.push_back(model(op_a, op_b, cin));
            end
            @(negedge clk);
            cyc++;
        end
        check("stream_count", cval_t'(got_n), cval_t'(10));
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
